// File: rtl/elevator_call_queue.sv
// elevator_call_queue: hall-call pending set with fixed-priority or LOOK-scan dequeue
module elevator_call_queue #(
   parameter int FLOORS = 4,
   parameter int FW     = 2,
   parameter int MODE   = 0,
   parameter int CW     = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [FW-1:0]     req_floor,
   input  logic              req_dir,
   input  logic              done,
   input  logic [FW-1:0]     cur_floor,
   input  logic              cur_dir,
   input  logic              flush,
   output logic              out_valid,
   output logic [FW-1:0]     out_floor,
   output logic              out_dir,
   output logic [FLOORS-1:0] pend_up,
   output logic [FLOORS-1:0] pend_dn,
   output logic [CW-1:0]     count,
   output logic              q_empty
);
   logic [FLOORS-1:0] pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
   logic              out_valid_q, out_valid_d, out_dir_q, out_dir_d;
   logic [FW-1:0]     out_floor_q, out_floor_d;
   logic              found, sel_d;
   logic [FW-1:0]     sel_f;
   int                cf;
   always_comb begin
      cf = (int'(cur_floor) >= FLOORS) ? FLOORS - 1 : int'(cur_floor);
      found = 1'b0;
      sel_f = '0;
      sel_d = 1'b0;
      if (MODE == 0) begin
         for (int i = 0; i < FLOORS; i++)
            if (!found && pend_up_q[i]) begin found = 1'b1; sel_f = FW'(i); sel_d = 1'b0; end
         for (int i = 0; i < FLOORS; i++)
            if (!found && pend_dn_q[i]) begin found = 1'b1; sel_f = FW'(i); sel_d = 1'b1; end
      end else if (!cur_dir) begin
         for (int i = 0; i < FLOORS; i++)
            if (!found && i >= cf && pend_up_q[i]) begin found = 1'b1; sel_f = FW'(i); sel_d = 1'b0; end
         for (int i = FLOORS - 1; i >= 0; i--)
            if (!found && pend_dn_q[i]) begin found = 1'b1; sel_f = FW'(i); sel_d = 1'b1; end
         for (int i = 0; i < FLOORS; i++)
            if (!found && i < cf && pend_up_q[i]) begin found = 1'b1; sel_f = FW'(i); sel_d = 1'b0; end
      end else begin
         for (int i = FLOORS - 1; i >= 0; i--)
            if (!found && i <= cf && pend_dn_q[i]) begin found = 1'b1; sel_f = FW'(i); sel_d = 1'b1; end
         for (int i = 0; i < FLOORS; i++)
            if (!found && pend_up_q[i]) begin found = 1'b1; sel_f = FW'(i); sel_d = 1'b0; end
         for (int i = FLOORS - 1; i >= 0; i--)
            if (!found && i > cf && pend_dn_q[i]) begin found = 1'b1; sel_f = FW'(i); sel_d = 1'b1; end
      end
   end
   // Request is set before the selected bit is cleared, so a matching same-cycle call is absorbed
   always_comb begin
      pend_up_d = pend_up_q;
      pend_dn_d = pend_dn_q;
      for (int i = 0; i < FLOORS; i++) begin
         if (req_valid && int'(req_floor) == i) begin
            if (!req_dir && i < FLOORS - 1) pend_up_d[i] = 1'b1;
            if (req_dir && i > 0) pend_dn_d[i] = 1'b1;
         end
         if (done && found && int'(sel_f) == i) begin
            if (sel_d) pend_dn_d[i] = 1'b0;
            else pend_up_d[i] = 1'b0;
         end
      end
      if (flush) begin
         pend_up_d = '0;
         pend_dn_d = '0;
      end
      out_valid_d = done && found && !flush;
      out_floor_d = out_valid_d ? sel_f : '0;
      out_dir_d   = out_valid_d & sel_d;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_up_q   <= '0;
         pend_dn_q   <= '0;
         out_valid_q <= 1'b0;
         out_floor_q <= '0;
         out_dir_q   <= 1'b0;
      end else begin
         pend_up_q   <= pend_up_d;
         pend_dn_q   <= pend_dn_d;
         out_valid_q <= out_valid_d;
         out_floor_q <= out_floor_d;
         out_dir_q   <= out_dir_d;
      end
   end
   always_comb begin
      count = '0;
      for (int i = 0; i < FLOORS; i++) count = count + CW'(pend_up_q[i]) + CW'(pend_dn_q[i]);
   end
   assign q_empty   = ~|{pend_up_q, pend_dn_q};
   assign pend_up   = pend_up_q;
   assign pend_dn   = pend_dn_q;
   assign out_valid = out_valid_q;
   assign out_floor = out_floor_q;
   assign out_dir   = out_dir_q;
endmodule

// File: tb/tb_elevator_call_queue.sv
// tb_elevator_call_queue: fixed-priority and LOOK instances run against a candidate-list reference model
module tb_elevator_call_queue;
   logic       clk = 0, rst_n = 1, req_valid = 0, req_dir = 0, done = 0, cur_dir = 0, flush = 0;
   logic [2:0] req_floor = '0, cur_floor = '0;
   logic       ov[2], od[2], qe[2];
   logic [2:0] of[2], cnt[2];
   logic [3:0] pu[2], pd[2];
   int         vectors = 0, miscompares = 0;
   logic [3:0] mu[2], md[2];
   logic       eov[2], eod[2];
   logic [2:0] eof[2];
   int         t2_f[5] = '{0, 1, 2, 3, 0};
   int         lu_f[4] = '{2, 3, 1, 0};
   int         lu_d[4] = '{0, 1, 1, 0};
   int         ld_f[4] = '{1, 0, 2, 3};
   int         ld_d[4] = '{1, 0, 0, 1};

   always #5 clk = ~clk;

   elevator_call_queue #(.FLOORS(4), .FW(3), .MODE(0), .CW(3)) u_fix (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor), .req_dir(req_dir),
      .done(done), .cur_floor(cur_floor), .cur_dir(cur_dir), .flush(flush),
      .out_valid(ov[0]), .out_floor(of[0]), .out_dir(od[0]), .pend_up(pu[0]), .pend_dn(pd[0]),
      .count(cnt[0]), .q_empty(qe[0]));

   elevator_call_queue #(.FLOORS(4), .FW(3), .MODE(1), .CW(3)) u_look (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor), .req_dir(req_dir),
      .done(done), .cur_floor(cur_floor), .cur_dir(cur_dir), .flush(flush),
      .out_valid(ov[1]), .out_floor(of[1]), .out_dir(od[1]), .pend_up(pu[1]), .pend_dn(pd[1]),
      .count(cnt[1]), .q_empty(qe[1]));

   // Candidates are encoded floor*2+dir and listed in the policy's visiting order
   function automatic int pick(int mode, logic [3:0] u, logic [3:0] d, int cf, logic cd);
      int order[$];
      int c;
      c = (cf > 3) ? 3 : cf;
      if (mode == 0) begin
         for (int f = 0; f < 4; f++) order.push_back(f * 2);
         for (int f = 0; f < 4; f++) order.push_back(f * 2 + 1);
      end else if (!cd) begin
         for (int f = c; f < 4; f++) order.push_back(f * 2);
         for (int f = 3; f >= 0; f--) order.push_back(f * 2 + 1);
         for (int f = 0; f < c; f++) order.push_back(f * 2);
      end else begin
         for (int f = c; f >= 0; f--) order.push_back(f * 2 + 1);
         for (int f = 0; f < 4; f++) order.push_back(f * 2);
         for (int f = 3; f > c; f--) order.push_back(f * 2 + 1);
      end
      foreach (order[k])
         if ((order[k] % 2 == 1) ? d[order[k] / 2] : u[order[k] / 2]) return order[k];
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("%s_u%0d_valid", tag, m), 8'(ov[m]), 8'(eov[m]));
         chk($sformatf("%s_u%0d_floor", tag, m), 8'(of[m]), 8'(eof[m]));
         chk($sformatf("%s_u%0d_dir", tag, m), 8'(od[m]), 8'(eod[m]));
         chk($sformatf("%s_u%0d_pend_up", tag, m), 8'(pu[m]), 8'(mu[m]));
         chk($sformatf("%s_u%0d_pend_dn", tag, m), 8'(pd[m]), 8'(md[m]));
         chk($sformatf("%s_u%0d_count", tag, m), 8'(cnt[m]), 8'($countones({mu[m], md[m]})));
         chk($sformatf("%s_u%0d_empty", tag, m), 8'(qe[m]), 8'({mu[m], md[m]} == 8'd0));
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mu[m] = '0; md[m] = '0; eov[m] = 0; eof[m] = '0; eod[m] = 0;
      end
   endtask

   task automatic step(input logic rv, input int rf, input logic rd, input logic dn,
                       input int cf, input logic cd, input logic fl, input string tag);
      req_valid = rv; req_floor = 3'(rf); req_dir = rd; done = dn;
      cur_floor = 3'(cf); cur_dir = cd; flush = fl;
      for (int m = 0; m < 2; m++) begin
         int p;
         logic [3:0] nu, nd;
         p = dn ? pick(m, mu[m], md[m], cf, cd) : -1;
         nu = mu[m]; nd = md[m];
         if (rv && rf < 4) begin
            if (!rd && rf != 3) nu[rf] = 1'b1;
            if (rd && rf != 0) nd[rf] = 1'b1;
         end
         if (p >= 0) begin
            if (p % 2 == 1) nd[p / 2] = 1'b0;
            else nu[p / 2] = 1'b0;
         end
         eov[m] = (p >= 0) && !fl;
         eof[m] = eov[m] ? 3'(p / 2) : 3'd0;
         eod[m] = eov[m] && (p % 2 == 1);
         mu[m] = fl ? 4'd0 : nu;
         md[m] = fl ? 4'd0 : nd;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic req(input int rf, input logic rd, input string tag);
      step(1, rf, rd, 0, 0, 0, 0, tag);
   endtask

   task automatic do_flush();
      step(0, 0, 0, 0, 0, 0, 1, "flush");
   endtask

   initial begin
      model_reset();
      #1 rst_n = 0;
      #1 check_all("por");
      #10 rst_n = 1;
      @(posedge clk);
      #1;
      // fixed-priority drain
      req(3, 1, "t2_req"); req(1, 0, "t2_req"); req(2, 1, "t2_req"); req(0, 0, "t2_req");
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 1, 0, 0, 0, "t2_deq");
         chk("t2_valid", 8'(ov[0]), 8'(k < 4));
         chk("t2_floor", 8'(of[0]), 8'(t2_f[k]));
         chk("t2_dir", 8'(od[0]), 8'(k == 2 || k == 3));
         if (k == 3) chk("t2_empty", 8'(qe[0]), 8'd1);
      end
      // asynchronous reset mid-cycle with calls pending and an output in flight
      req(2, 0, "t1_req"); req(3, 1, "t1_req"); req(1, 1, "t1_req");
      step(0, 0, 0, 1, 0, 0, 0, "t1_deq");
      #3 rst_n = 0;
      model_reset();
      #1;
      chk("t1_empty", 8'(qe[0]), 8'd1);
      chk("t1_count", 8'(cnt[0]), 8'd0);
      chk("t1_valid", 8'(ov[0]), 8'd0);
      check_all("t1_rst");
      #2 rst_n = 1;
      @(posedge clk);
      #1;
      check_all("t1_rel");
      // illegal and duplicate calls
      req(3, 0, "t3_req"); req(0, 1, "t3_req"); req(5, 0, "t3_req"); req(1, 0, "t3_req"); req(1, 0, "t3_req");
      chk("t3_count", 8'(cnt[0]), 8'd1);
      chk("t3_pend_up", 8'(pu[0]), 8'b0010);
      do_flush();
      // LOOK scan, both directions
      for (int pass = 0; pass < 2; pass++) begin
         req(0, 0, "t4_req"); req(3, 1, "t4_req"); req(2, 0, "t4_req"); req(1, 1, "t4_req");
         for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 2, 1'(pass), 0, "t4_deq");
            chk("t4_floor", 8'(of[1]), 8'(pass == 0 ? lu_f[k] : ld_f[k]));
            chk("t4_dir", 8'(od[1]), 8'(pass == 0 ? lu_d[k] : ld_d[k]));
         end
      end
      // same-cycle absorb and same-cycle distinct request
      req(1, 0, "t5_req");
      step(1, 1, 0, 1, 0, 0, 0, "t5_abs");
      chk("t5_abs_valid", 8'(ov[0]), 8'd1);
      chk("t5_abs_floor", 8'(of[0]), 8'd1);
      chk("t5_abs_count", 8'(cnt[0]), 8'd0);
      chk("t5_abs_empty", 8'(qe[0]), 8'd1);
      req(1, 0, "t5_req");
      step(1, 2, 1, 1, 0, 0, 0, "t5_mix");
      chk("t5_mix_floor", 8'(of[0]), 8'd1);
      chk("t5_mix_count", 8'(cnt[0]), 8'd1);
      chk("t5_mix_pend_dn", 8'(pd[0][2]), 8'd1);
      do_flush();
      // flush beats same-cycle done and request
      req(0, 0, "t6_req"); req(2, 1, "t6_req"); req(3, 1, "t6_req");
      step(1, 1, 0, 1, 0, 0, 1, "t6_flush");
      chk("t6_valid", 8'(ov[0]), 8'd0);
      chk("t6_count", 8'(cnt[0]), 8'd0);
      chk("t6_empty", 8'(qe[0]), 8'd1);
      // randomized traffic including out-of-range floors and car positions
      for (int k = 0; k < 400; k++)
         step($urandom_range(9) < 7, int'($urandom_range(5)), 1'($urandom_range(1)),
              $urandom_range(9) < 4, int'($urandom_range(7)), 1'($urandom_range(1)),
              $urandom_range(31) == 0, "rnd");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/elevator_call_queue.md
# elevator_call_queue

Parametrised hall-call request queue for an N-floor elevator controller. It latches up and down hall calls into a per-floor pending set and merges duplicates. When the controller pulses `done`, it dequeues one call using either fixed-priority order or a direction-aware LOOK scan. It sits between the hall-button decoder and the elevator FSM, as the next generation of the 4-floor fixed-priority call buffer.

## Interface
- `FLOORS`, default 4: number of floors, indices 0..FLOORS-1, minimum 2.
- `FW`, default 2: floor index width, equal to clog2(FLOORS).
- `MODE`, default 0: selection policy. 0 = fixed priority. 1 = LOOK scan.
- `CW`, default 3: count width, equal to clog2(2*FLOORS).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  hall-call strobe for this cycle.
- `req_floor`  in  FW  floor of the call.
- `req_dir`  in  1  direction of the call: 0 = up, 1 = down.
- `done`  in  1  dequeue request from the FSM.
- `cur_floor`  in  FW  car position (used only when MODE=1).
- `cur_dir`  in  1  car travel direction, 0 = up, 1 = down (used only when MODE=1).
- `flush`  in  1  synchronous clear of all pending calls.
- `out_valid`  out  1  one-cycle pulse: a call was dequeued.
- `out_floor`  out  FW  floor of the dequeued call; 0 when `out_valid`=0.
- `out_dir`  out  1  direction of the dequeued call; 0 when `out_valid`=0.
- `pend_up`  out  FLOORS  pending up-call bit per floor.
- `pend_dn`  out  FLOORS  pending down-call bit per floor.
- `count`  out  CW  number of pending calls.
- `q_empty`  out  1  high when no calls are pending.

## Operation
- **State.** Registers `pend_up`, `pend_dn`, `out_valid`, `out_floor`, `out_dir`. `count` and `q_empty` are combinational from the pend registers.
- **Legal calls.** Up calls are legal on floors 0..FLOORS-2. Down calls are legal on floors 1..FLOORS-1.
- **Dropped calls.** The block silently drops three kinds of request:
  - an up call at the top floor;
  - a down call at floor 0;
  - any call with `req_floor` >= FLOORS.
  The corresponding `pend_up[FLOORS-1]` and `pend_dn[0]` bits are constant 0.
- **Duplicates.** A call whose bit is already set leaves state unchanged.
- **Dequeue.** When `done`=1 and the queue is not empty, the block selects one call from the pre-edge pend state. It clears that bit and registers `out_valid`=1 with the call's floor and direction. When `done`=1 and the queue is empty, `out_valid`=0.
- **MODE=0 search order.** First: up calls, floor 0 ascending. Then: down calls, floor 1 ascending.
- **MODE=1, cur_dir=up, search order:**
  1. Up calls at floors >= `cur_floor`, ascending.
  2. Down calls, descending from the top floor.
  3. Up calls at floors below `cur_floor`, ascending.
- **MODE=1, cur_dir=down, search order:**
  1. Down calls at floors <= `cur_floor`, descending.
  2. Up calls, ascending from floor 0.
  3. Down calls at floors above `cur_floor`, descending.
- **Out-of-range car position.** A `cur_floor` >= FLOORS is clamped to FLOORS-1.
- **Flush.** `flush` clears both pend vectors and forces `out_valid`=0. It overrides a same-cycle request and a same-cycle `done`.

## Timing
- **Reset.** While `rst_n`=0, all of the following hold immediately, with no clock required:
  - `pend_up`=0, `pend_dn`=0;
  - `out_valid`=0, `out_floor`=0, `out_dir`=0;
  - `count`=0, `q_empty`=1.
- **Reset release.** State holds its reset values until the first rising edge after `rst_n` goes high. Reset mid-operation discards all pending calls and any in-flight output.
- **Request latency.** A request sampled at edge t appears in `pend_*` and `count` after edge t.
- **Dequeue latency.** `done` sampled at edge t gives `out_valid`, `out_floor` and `out_dir` valid for exactly the cycle following edge t. These outputs return to 0 after the next edge unless `done` is high again.
- **Back-to-back dequeue.** `done` held high dequeues one call per cycle until the queue is empty.
- **Request and done in the same cycle:**
  - Selection uses the pre-edge state and never selects the same-cycle request.
  - If the same-cycle request matches the selected call, it is absorbed: the bit ends cleared and `count` drops by 1.
  - If it differs, the request's bit is set and the selected bit is cleared, so `count` is unchanged.
- **Saturation.** `count` reaches at most 2*FLOORS-2 and never wraps.

## Test plan
1. **Reset.** FLOORS=4, MODE=0. Assert `rst_n`=0 mid-cycle with calls pending → outputs clear without a clock edge: `q_empty`=1, `count`=0, `out_valid`=0.
2. **Fixed-priority drain.** MODE=0. Request, on separate cycles: floor 3 down, floor 1 up, floor 2 down, floor 0 up. Then hold `done` for 5 cycles → outputs in order (0,up), (1,up), (2,dn), (3,dn), then `out_valid`=0. `q_empty`=1 after the 4th dequeue.
3. **Illegal and duplicate calls.** Request: floor 3 up, floor 0 down, floor 5 (with FW=3, FLOORS=4), and floor 1 up twice → `count`=1 and `pend_up`=4'b0010.
4. **LOOK scan.** MODE=1, `cur_floor`=2, `cur_dir`=up, pending calls 0 up, 3 down, 2 up, 1 down. Pulse `done` 4 times → (2,up), (3,dn), (1,dn), (0,up). Repeat with `cur_dir`=down and `cur_floor`=2 → (1,dn), (0,up), (2,up), (3,dn).
5. **Same-cycle absorb.** Only 1 up pending. Present request 1 up together with `done` → `out_valid`=1 with (1,up), then `count`=0 and `q_empty`=1. Repeat with request 2 down instead → output (1,up), then `count`=1 and `pend_dn[2]`=1.
6. **Flush priority.** Three calls pending. Assert `flush` together with `done` and a new request → `out_valid`=0 next cycle, `count`=0, `q_empty`=1.
